param_expr_pipe: RTL and testbench
==================================

// Module: param_expr_pipe
// PURPOSE
//  Parametrised 4-stage pipelined arithmetic unit computing res = [acc +] a*b + c -/+ d*e.
//  Successor of the fixed 3-bit expression pipeline: generic WIDTH, valid/ready flow control
//  with back-pressure, per-beat op select, accumulate mode, wrap/saturate output, overflow flag.
//  Sits between an operand source and a result sink in the datapath.
// PARAMETERS
//  WIDTH   8   operand and result width (unsigned operands), WIDTH >= 2
//  SAT     0   0 = wrap (keep low WIDTH bits), 1 = clamp to [0, 2^WIDTH-1]
// PORTS
//  clk        in   1      rising-edge clock
//  clear      in   1      asynchronous active-high reset
//  flush      in   1      synchronous pipeline flush: drops all in-flight beats, zeroes acc
//  in_valid   in   1      input beat valid
//  in_ready   out  1      unit can accept a beat this cycle
//  op         in   2      op[0]: 1 = +d*e, 0 = -d*e; op[1]: 1 = accumulate into acc
//  a,b,c,d,e  in   WIDTH  unsigned operands
//  out_valid  out  1      res/ovf valid
//  out_ready  in   1      sink accepts res this cycle
//  res        out  WIDTH  result
//  ovf        out  1      full-precision result outside [0, 2^WIDTH-1]
// BEHAVIOUR
//  - Reset (clear=1, async): all stage valids, out_valid, res, ovf, acc = 0. Data regs = 0.
//  - Stages: S1 operand capture; S2 p1=a*b, p2=d*e (2W unsigned), c, op forwarded;
//    S3 s=p1+c; S4 e=s-/+p2, final = op[1] ? acc+e : e, output formatting.
//  - Internal signed precision: ACC_W = 2*WIDTH+4; no internal truncation before S4 format.
//  - Handshake: beat accepted on edge where in_valid & in_ready. stall = out_valid & !out_ready.
//    in_ready = !stall (combinational from out_ready). On stall all stages hold; no beat lost.
//  - Latency: beat accepted at end of cycle n appears on res with out_valid in cycle n+4
//    (no stall). Throughput 1 beat/cycle. Bubbles propagate as invalid stages (no collapse).
//  - Output transfer completes on edge where out_valid & out_ready; out_valid drops next
//    cycle unless a new beat enters S4 that edge. res/ovf stable while stalled.
//  - acc: updated to final each time a valid beat enters S4 (both op[1]=0 and 1).
//    op[1]=0 beat thus restarts accumulation from its own e.
//  - Format: ovf = (final<0) | (final>2^WIDTH-1). SAT=0: res = final[WIDTH-1:0].
//    SAT=1: final<0 -> 0; final>max -> 2^WIDTH-1; else final.
//  - flush: on the edge, all valids <= 0, acc <= 0, out_valid <= 0; input beat offered
//    that cycle is NOT accepted (in_ready forced 0 while flush=1). flush beats stall.
//  - clear mid-operation: outputs zero immediately, pipeline empty; resumes accepting
//    the first cycle after clear deasserts.
//  - acc wrap: ACC_W signed two's-complement wrap; ovf reports against WIDTH only.
// TESTING (WIDTH=8 unless noted)
//  1 a=3,b=4,c=5,d=2,e=6,op=00, out_ready=1 -> cycle n+4: res=5, ovf=0; op=01 -> res=29.
//  2 a=1,b=1,c=0,d=3,e=3,op=00 -> final=-8: SAT=0 res=0xF8 ovf=1; SAT=1 res=0 ovf=1.
//    a=b=c=d=e=255,op=01 -> final=130305: SAT=0 res=1 ovf=1; SAT=1 res=255 ovf=1.
//  3 Accumulate: beats (3,4,5,2,6) op=10, op=10, op=00 back-to-back -> res 5,10,5; acc=5.
//  4 Stream 6 beats, hold out_ready=0 for 3 cycles mid-stream -> in_ready=0 during stall,
//    res held stable, all 6 results delivered in order, none duplicated.
//  5 clear pulse with 3 beats in flight -> out_valid=0, res=0 same cycle; next accum beat
//    (expr 5, op=10) after clear -> res=5. Repeat with flush -> same, flush-cycle beat dropped.

Source files
------------

// File: rtl/param_expr_pipe.sv
// Four-stage pipelined unit: res = [acc +] a*b + c -/+ d*e, valid/ready with back-pressure,
// optional accumulate, wrap or saturate output formatting and an overflow flag.
module param_expr_pipe #(
    parameter int WIDTH = 8,
    parameter bit SAT   = 1'b0
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    input  logic [WIDTH-1:0] d,
    input  logic [WIDTH-1:0] e,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] res,
    output logic             ovf
);

    localparam int STAGES = 4;
    localparam int P_W    = 2 * WIDTH;
    localparam int ACC_W  = 2 * WIDTH + 4;
    localparam logic signed [ACC_W-1:0] RMAX = {{(ACC_W-WIDTH){1'b0}}, {WIDTH{1'b1}}};

    typedef struct packed {
        logic [1:0]       op;
        logic [WIDTH-1:0] a, b, c, d, e;
    } s1_t;

    typedef struct packed {
        logic [1:0]       op;
        logic [P_W-1:0]   p1, p2;
        logic [WIDTH-1:0] c;
    } s2_t;

    typedef struct packed {
        logic [1:0]     op;
        logic [P_W:0]   s;
        logic [P_W-1:0] p2;
    } s3_t;

    logic [STAGES:1] vld_pipe;
    s1_t s1;
    s2_t s2;
    s3_t s3;
    logic signed [ACC_W-1:0] acc, expr, fin;
    logic                    stall, advance, fin_neg, fin_big, ovf_n;
    logic [WIDTH-1:0]        res_n;

    assign out_valid = vld_pipe[STAGES];
    assign stall     = out_valid & ~out_ready;
    assign in_ready  = ~stall & ~flush;
    assign advance   = ~stall;

    // S4 combinational: full-precision signed result and its formatted form.
    always_comb begin
        expr = '0;
        if (s3.op[0])
            expr = ACC_W'(s3.s) + ACC_W'(s3.p2);
        else
            expr = ACC_W'(s3.s) - ACC_W'(s3.p2);
        fin     = s3.op[1] ? acc + expr : expr;
        fin_neg = fin[ACC_W-1];
        fin_big = ~fin_neg & (fin > RMAX);
        ovf_n   = fin_neg | fin_big;
        res_n   = fin[WIDTH-1:0];
        if (SAT) begin
            if (fin_neg)
                res_n = '0;
            else if (fin_big)
                res_n = '1;
        end
    end

    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            vld_pipe <= '0;
            s1       <= '0;
            s2       <= '0;
            s3       <= '0;
            acc      <= '0;
            res      <= '0;
            ovf      <= 1'b0;
        end else if (flush) begin
            vld_pipe <= '0;
            acc      <= '0;
        end else if (advance) begin
            vld_pipe <= {vld_pipe[STAGES-1:1], in_valid & in_ready};
            s1       <= '{op: op, a: a, b: b, c: c, d: d, e: e};
            s2.op    <= s1.op;
            s2.p1    <= P_W'(s1.a) * P_W'(s1.b);
            s2.p2    <= P_W'(s1.d) * P_W'(s1.e);
            s2.c     <= s1.c;
            s3.op    <= s2.op;
            s3.s     <= (P_W+1)'(s2.p1) + (P_W+1)'(s2.c);
            s3.p2    <= s2.p2;
            // Only real beats touch acc and the output registers; bubbles leave them alone.
            if (vld_pipe[STAGES-1]) begin
                acc <= fin;
                res <= res_n;
                ovf <= ovf_n;
            end
        end
    end

endmodule

// File: tb/tb_param_expr_pipe.sv
// Scoreboard bench for param_expr_pipe: wrap and saturate instances side by side,
// expected results from an integer reference model, checked by an independent monitor.
module tb_param_expr_pipe;

    localparam int W     = 8;
    localparam int ACC_W = 2 * W + 4;

    typedef struct {
        logic [W-1:0] r0;
        logic         o0;
        logic [W-1:0] r1;
        logic         o1;
    } exp_t;

    logic clk = 1'b0;
    logic clear, flush, in_valid, out_ready;
    logic [1:0] op;
    logic [W-1:0] a, b, c, d, e;
    logic in_ready0, in_ready1, out_valid0, out_valid1, ovf0, ovf1;
    logic [W-1:0] res0, res1;

    int     errors = 0;
    int     checks = 0;
    int     hold = 0;
    int     rdy_pct = 100;
    longint macc = 0;
    exp_t   q[$];

    always #5 clk = ~clk;

    param_expr_pipe #(.WIDTH(W), .SAT(1'b0)) u_wrap (
        .clk(clk), .clear(clear), .flush(flush), .in_valid(in_valid), .in_ready(in_ready0),
        .op(op), .a(a), .b(b), .c(c), .d(d), .e(e),
        .out_valid(out_valid0), .out_ready(out_ready), .res(res0), .ovf(ovf0));

    param_expr_pipe #(.WIDTH(W), .SAT(1'b1)) u_sat (
        .clk(clk), .clear(clear), .flush(flush), .in_valid(in_valid), .in_ready(in_ready1),
        .op(op), .a(a), .b(b), .c(c), .d(d), .e(e),
        .out_valid(out_valid1), .out_ready(out_ready), .res(res1), .ovf(ovf1));

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: plain integer arithmetic, accumulator wrapped to ACC_W signed bits.
    function automatic exp_t model(input int ia, ib, ic, id, ie, input logic [1:0] iop);
        longint p, f;
        exp_t   r;
        p = longint'(ia) * ib + ic + (iop[0] ? longint'(id) * ie : -(longint'(id) * ie));
        f = iop[1] ? macc + p : p;
        f = f & ((64'sd1 << ACC_W) - 1);
        if (f >= (64'sd1 << (ACC_W - 1)))
            f = f - (64'sd1 << ACC_W);
        macc = f;
        r.o0 = (f < 0) || (f > 255);
        r.r0 = f[W-1:0];
        r.o1 = r.o0;
        r.r1 = (f < 0) ? 8'd0 : (f > 255) ? 8'd255 : f[W-1:0];
        return r;
    endfunction

    // Monitor: compares whenever an output is presented; pops only on transfer.
    initial forever begin
        @(negedge clk);
        #2;
        if (out_valid0) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output: got res=%0d with no beat expected", res0);
            end else begin
                chk("res_wrap", res0, q[0].r0);
                chk("ovf_wrap", ovf0, q[0].o0);
                chk("out_valid_sat", out_valid1, 1);
                chk("res_sat", res1, q[0].r1);
                chk("ovf_sat", ovf1, q[0].o1);
                if (out_ready)
                    void'(q.pop_front());
            end
        end
    end

    task automatic tick(input bit v, input int ia, ib, ic, id, ie, input logic [1:0] iop,
                        output bit accepted);
        @(negedge clk);
        clear = 1'b0;
        flush = 1'b0;
        if (hold > 0) begin
            out_ready = 1'b0;
            hold--;
        end else begin
            out_ready = ($urandom_range(99) < rdy_pct);
        end
        in_valid = v;
        a = ia[W-1:0]; b = ib[W-1:0]; c = ic[W-1:0]; d = id[W-1:0]; e = ie[W-1:0];
        op = iop;
        #1;
        chk("in_ready", in_ready0, !(out_valid0 && !out_ready));
        chk("in_ready_sat", in_ready1, !(out_valid0 && !out_ready));
        accepted = v && in_ready0;
        if (accepted)
            q.push_back(model(ia, ib, ic, id, ie, iop));
    endtask

    task automatic idle(input int n);
        bit ok;
        for (int i = 0; i < n; i++)
            tick(1'b0, 0, 0, 0, 0, 0, 2'b00, ok);
    endtask

    task automatic send(input int ia, ib, ic, id, ie, input logic [1:0] iop);
        bit ok;
        int n;
        n = 0;
        ok = 1'b0;
        while (!ok && n < 100) begin
            tick(1'b1, ia, ib, ic, id, ie, iop, ok);
            n++;
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: got no acceptance in %0d cycles, required acceptance", n);
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() > 0 && n < 300) begin
            idle(1);
            n++;
        end
        chk("drain_empty", q.size(), 0);
        idle(3);
    endtask

    task automatic do_clear();
        @(negedge clk);
        clear = 1'b1;
        in_valid = 1'b0;
        #1;
        chk("clear_out_valid", out_valid0, 0);
        chk("clear_res", res0, 0);
        chk("clear_ovf", ovf0, 0);
        q.delete();
        macc = 0;
    endtask

    task automatic do_flush();
        @(negedge clk);
        flush = 1'b1;
        out_ready = 1'b0;
        in_valid = 1'b1;
        a = 8'd9; b = 8'd9; c = 8'd9; d = 8'd1; e = 8'd1; op = 2'b11;
        #1;
        chk("flush_in_ready", in_ready0, 0);
        @(posedge clk);
        #1;
        chk("flush_out_valid", out_valid0, 0);
        q.delete();
        macc = 0;
    endtask

    initial begin
        bit ok;
        int ia, ib, ic, id, ie;
        logic [1:0] iop;
        clear = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        op = '0; a = '0; b = '0; c = '0; d = '0; e = '0;
        @(negedge clk);
        #1;
        chk("reset_out_valid", out_valid0, 0);
        chk("reset_res", res0, 0);
        chk("reset_ovf", ovf0, 0);
        chk("reset_in_ready", in_ready0, 1);

        // Basic expression and four-cycle latency.
        rdy_pct = 100;
        send(3, 4, 5, 2, 6, 2'b00);
        for (int k = 1; k <= 3; k++) begin
            tick(1'b0, 0, 0, 0, 0, 0, 2'b00, ok);
            chk("latency_not_yet", out_valid0, 0);
        end
        tick(1'b0, 0, 0, 0, 0, 0, 2'b00, ok);
        chk("latency_n_plus_4", out_valid0, 1);
        send(3, 4, 5, 2, 6, 2'b01);
        drain();

        // Underflow and full-scale overflow.
        send(1, 1, 0, 3, 3, 2'b00);
        send(255, 255, 255, 255, 255, 2'b01);
        drain();

        // Accumulate back-to-back, then a restart beat.
        send(3, 4, 5, 2, 6, 2'b10);
        send(3, 4, 5, 2, 6, 2'b10);
        send(3, 4, 5, 2, 6, 2'b00);
        drain();

        // Six-beat stream with a three-cycle sink stall in the middle.
        for (int i = 0; i < 3; i++) send(i + 1, 2, 3, 1, i, 2'b01);
        hold = 3;
        for (int i = 0; i < 3; i++) send(i + 7, 3, 1, 2, i, 2'b00);
        drain();

        // Clear with beats in flight, then accumulation restarts from zero.
        for (int i = 0; i < 3; i++) send(10 + i, 3, 2, 1, 1, 2'b11);
        do_clear();
        send(3, 4, 5, 2, 6, 2'b10);
        drain();

        // Same with flush; the beat offered during the flush must be dropped.
        for (int i = 0; i < 3; i++) send(20 + i, 2, 2, 1, 1, 2'b11);
        do_flush();
        send(3, 4, 5, 2, 6, 2'b10);
        drain();

        // Randomised traffic with bubbles and a randomly stalling sink.
        rdy_pct = 70;
        for (int i = 0; i < 400; i++) begin
            ia = ($urandom_range(7) == 0) ? 255 : $urandom_range(255);
            ib = $urandom_range(255);
            ic = $urandom_range(255);
            id = ($urandom_range(7) == 0) ? 255 : $urandom_range(255);
            ie = $urandom_range(255);
            iop = 2'($urandom_range(3));
            tick($urandom_range(99) < 80, ia, ib, ic, id, ie, iop, ok);
            if (i == 200) do_flush();
        end
        rdy_pct = 100;
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
